// File: rtl/spi_arb_pkg.sv
// Shared types and widths for the two-client SPI transaction arbiter.
package spi_arb_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned GUARD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_GUARD = 2'd3
  } state_t;

  typedef logic client_t;

  function automatic client_t other_client(input client_t c);
    return client_t'(~c);
  endfunction

endpackage

// File: rtl/spi_arbiter_if.sv
// Client-side request/grant/data bundle between the sensor interfaces and the arbiter.
interface spi_arbiter_if;
  import spi_arb_pkg::*;

  logic              req0;
  logic              req1;
  logic [DATA_W-1:0] wt_data0;
  logic [DATA_W-1:0] wt_data1;
  logic              gnt0;
  logic              gnt1;
  logic              done0;
  logic              done1;
  logic [DATA_W-1:0] rd_data;
  logic              busy;

  modport master (
    output req0, req1, wt_data0, wt_data1,
    input  gnt0, gnt1, done0, done1, rd_data, busy
  );

  modport slave (
    input  req0, req1, wt_data0, wt_data1,
    output gnt0, gnt1, done0, done1, rd_data, busy
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin pick; the pointer favours one client on a tie and
// flips to the other client after each grant taken while enabled.
module rr_arb2
  import spi_arb_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    en,
  input  logic    req0,
  input  logic    req1,
  output client_t pick_c,
  output logic    any_c
);

  client_t ptr;

  always_comb begin
    any_c  = req0 | req1;
    pick_c = client_t'(1'b0);
    if (req0 && req1) begin
      pick_c = ptr;
    end else if (req1) begin
      pick_c = client_t'(1'b1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= client_t'(1'b0);
    end else if (en && any_c) begin
      ptr <= other_client(pick_c);
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPI transaction engine between two clients, whole transactions at a
// time, with round-robin arbitration, chip-select/MISO routing and a guard gap.
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned GUARD_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_arbiter_if.slave      bus,
  output logic              spi_wrt,
  output logic [DATA_W-1:0] spi_wt_data,
  input  logic              spi_done,
  input  logic [DATA_W-1:0] spi_rd_data,
  input  logic              spi_SS_n,
  output logic              SS0_n,
  output logic              SS1_n,
  input  logic              MISO0,
  input  logic              MISO1,
  output logic              spi_MISO
);

  state_t             state_q, state_d;
  client_t            sel_q, sel_d;
  logic [1:0]         gnt_q, gnt_d;
  logic [1:0]         done_q, done_d;
  logic               wrt_q, wrt_d;
  logic               busy_q, busy_d;
  logic [DATA_W-1:0]  wt_q, wt_d;
  logic [DATA_W-1:0]  rd_q, rd_d;
  logic [GUARD_W-1:0] cnt_q, cnt_d;

  client_t pick_c;
  logic    any_c;
  logic    route_c;

  rr_arb2 u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (state_q == ST_IDLE),
    .req0   (bus.req0),
    .req1   (bus.req1),
    .pick_c (pick_c),
    .any_c  (any_c)
  );

  // Next-state and next-output logic; requests are only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    done_d  = 2'b00;
    wrt_d   = 1'b0;
    wt_d    = wt_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (any_c) begin
          state_d = ST_ISSUE;
          sel_d   = pick_c;
          gnt_d   = pick_c ? 2'b10 : 2'b01;
          wt_d    = pick_c ? bus.wt_data1 : bus.wt_data0;
          wrt_d   = 1'b1;
        end
      end
      ST_ISSUE: begin
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (spi_done) begin
          state_d = ST_GUARD;
          rd_d    = spi_rd_data;
          done_d  = gnt_q;
          cnt_d   = GUARD_W'(GUARD_CYC);
        end
      end
      ST_GUARD: begin
        // Grant falls on the same edge that ends the done pulse.
        gnt_d = 2'b00;
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - GUARD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= client_t'(1'b0);
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      wrt_q   <= 1'b0;
      busy_q  <= 1'b0;
      wt_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      wrt_q   <= wrt_d;
      busy_q  <= busy_d;
      wt_q    <= wt_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  // Chip-select and MISO routing depend only on registered sel/grant/state.
  always_comb begin
    route_c  = (|gnt_q) || (state_q == ST_GUARD);
    SS0_n    = (route_c && !sel_q) ? spi_SS_n : 1'b1;
    SS1_n    = (route_c &&  sel_q) ? spi_SS_n : 1'b1;
    spi_MISO = sel_q ? MISO1 : MISO0;
  end

  assign bus.gnt0    = gnt_q[0];
  assign bus.gnt1    = gnt_q[1];
  assign bus.done0   = done_q[0];
  assign bus.done1   = done_q[1];
  assign bus.rd_data = rd_q;
  assign bus.busy    = busy_q;
  assign spi_wrt     = wrt_q;
  assign spi_wt_data = wt_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Bench for spi_arbiter: bit-serial engine and peripheral models, a timestamp-based
// transaction model checked every cycle, and directed scenarios with literal checks.
module tb_spi_arbiter;
  import spi_arb_pkg::*;

  localparam int unsigned G = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_arbiter_if bus ();

  logic        spi_wrt, spi_done, spi_SS_n, SS0_n, SS1_n, MISO0, MISO1, spi_MISO;
  logic [15:0] spi_wt_data, spi_rd_data;

  spi_arbiter #(.GUARD_CYC(G)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .spi_wrt     (spi_wrt),
    .spi_wt_data (spi_wt_data),
    .spi_done    (spi_done),
    .spi_rd_data (spi_rd_data),
    .spi_SS_n    (spi_SS_n),
    .SS0_n       (SS0_n),
    .SS1_n       (SS1_n),
    .MISO0       (MISO0),
    .MISO1       (MISO1),
    .spi_MISO    (spi_MISO)
  );

  // Engine model: 16 bits shifted in from spi_MISO while SS_n low, then done.
  logic        eng_ss_n, eng_done, stray_done;
  logic [15:0] eng_rx, eng_rd;
  int          eng_cnt;
  assign spi_SS_n    = eng_ss_n;
  assign spi_done    = eng_done | stray_done;
  assign spi_rd_data = stray_done ? 16'hDEAD : eng_rd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_ss_n <= 1'b1; eng_done <= 1'b0; eng_rx <= '0; eng_rd <= '0; eng_cnt <= 0;
    end else begin
      eng_done <= 1'b0;
      if (spi_wrt && eng_ss_n) begin
        eng_ss_n <= 1'b0;
        eng_cnt  <= 0;
      end else if (!eng_ss_n) begin
        eng_rx  <= {eng_rx[14:0], spi_MISO};
        eng_cnt <= eng_cnt + 1;
        if (eng_cnt == 15) begin
          eng_ss_n <= 1'b1;
          eng_done <= 1'b1;
          eng_rd   <= {eng_rx[14:0], spi_MISO};
        end
      end
    end
  end

  // Peripherals: shift out their response while selected, reload while deselected.
  logic [15:0] rsp0, rsp1;
  logic [15:0] sh0 = '0, sh1 = '0;
  always @(posedge clk) begin
    sh0 <= SS0_n ? rsp0 : {sh0[14:0], 1'b0};
    sh1 <= SS1_n ? rsp1 : {sh1[14:0], 1'b0};
  end
  assign MISO0 = sh0[15];
  assign MISO1 = sh1[15];

  // Transaction model: each grant is a timeline of cycle stamps.
  int          cyc = 0;
  bit          m_act, m_own, m_dknown, m_ptr, m_sel;
  int          m_start, m_dcyc, m_free;
  logic [15:0] m_rd, m_wt;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      m_act = 0; m_own = 0; m_dknown = 0; m_ptr = 0; m_sel = 0;
      m_start = 0; m_dcyc = 0; m_free = 0; m_rd = '0; m_wt = '0;
    end else if (m_act && !m_dknown && (cyc - 1) > m_start && spi_done) begin
      m_dknown = 1; m_dcyc = cyc; m_free = cyc + G + 1; m_rd = spi_rd_data;
    end else if (!m_act || (m_dknown && (cyc - 1) >= m_free)) begin
      if (bus.req0 || bus.req1) begin
        m_own    = (bus.req0 && bus.req1) ? m_ptr : bus.req1;
        m_ptr    = !m_own;
        m_sel    = m_own;
        m_wt     = m_own ? bus.wt_data1 : bus.wt_data0;
        m_act    = 1; m_dknown = 0; m_start = cyc;
      end
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  int wrt_cyc[$], wrt_own[$];
  logic [15:0] wrt_wt[$];
  int n_done0, n_done1;
  bit saw_gnt1, saw_ss1;
  bit e_tx, e_g, e_dn;

  // Per-cycle comparison against the model, plus event logging.
  always @(posedge clk) begin
    #3;
    e_tx = m_act && cyc >= m_start && (!m_dknown || cyc < m_free);
    e_g  = m_act && cyc >= m_start && (!m_dknown || cyc <= m_dcyc);
    e_dn = m_act && m_dknown && cyc == m_dcyc;
    chk("gnt0", 32'(bus.gnt0), 32'(e_g && !m_own));
    chk("gnt1", 32'(bus.gnt1), 32'(e_g && m_own));
    chk("done0", 32'(bus.done0), 32'(e_dn && !m_own));
    chk("done1", 32'(bus.done1), 32'(e_dn && m_own));
    chk("spi_wrt", 32'(spi_wrt), 32'(m_act && cyc == m_start));
    chk("busy", 32'(bus.busy), 32'(e_tx));
    chk("rd_data", 32'(bus.rd_data), 32'(m_rd));
    chk("spi_wt_data", 32'(spi_wt_data), 32'(m_wt));
    chk("SS0_n", 32'(SS0_n), 32'((e_tx && !m_sel) ? spi_SS_n : 1'b1));
    chk("SS1_n", 32'(SS1_n), 32'((e_tx && m_sel) ? spi_SS_n : 1'b1));
    chk("spi_MISO", 32'(spi_MISO), 32'(m_sel ? MISO1 : MISO0));
    if (spi_wrt) begin
      wrt_cyc.push_back(cyc);
      wrt_own.push_back(int'(bus.gnt1));
      wrt_wt.push_back(spi_wt_data);
    end
    if (bus.gnt1) saw_gnt1 = 1;
    if (!SS1_n) saw_ss1 = 1;
    if (bus.done0) n_done0++;
    if (bus.done1) n_done1++;
  end

  task automatic clear_logs();
    wrt_cyc.delete(); wrt_own.delete(); wrt_wt.delete();
    n_done0 = 0; n_done1 = 0; saw_gnt1 = 0; saw_ss1 = 0;
  endtask

  task automatic wait_done(input int who, input int lim);
    int k = 0;
    while (!(who != 0 ? bus.done1 : bus.done0) && k < lim) begin
      @(negedge clk); k++;
    end
    chk("wait_done", 32'(k < lim), 32'd1);
  endtask

  task automatic wait_wrts(input int n, input int lim);
    int k = 0;
    while (wrt_cyc.size() < n && k < lim) begin
      @(negedge clk); k++;
    end
    chk("wait_wrt", 32'(k < lim), 32'd1);
  endtask

  task automatic wait_gnt(input int who, input int lim);
    int k = 0;
    while (!(who != 0 ? bus.gnt1 : bus.gnt0) && k < lim) begin
      @(negedge clk); k++;
    end
    chk("wait_gnt", 32'(k < lim), 32'd1);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; stray_done = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.wt_data0 = '0; bus.wt_data1 = '0;
    rsp0 = 16'h0012; rsp1 = 16'hBEEF;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'({bus.gnt1, bus.gnt0}), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ss", 32'({SS1_n, SS0_n}), 32'd3);
    chk("rst_rd", 32'(bus.rd_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single client 0 transaction.
    clear_logs();
    bus.wt_data0 = 16'hA700; bus.req0 = 1'b1;
    wait_done(0, 60);
    chk("t1_rd", 32'(bus.rd_data), 32'h0012);
    bus.req0 = 1'b0;
    repeat (10) @(negedge clk);
    chk("t1_nwrt", 32'(wrt_cyc.size()), 32'd1);
    if (wrt_wt.size() > 0) chk("t1_wt", 32'(wrt_wt[0]), 32'hA700);
    chk("t1_gnt1", 32'(saw_gnt1), 32'd0);
    chk("t1_ss1", 32'(saw_ss1), 32'd0);
    chk("t1_ndone0", 32'(n_done0), 32'd1);

    // Both requesting from reset: alternate 0,1,0,1.
    pulse_reset();
    clear_logs();
    rsp1 = 16'h5A5A; bus.wt_data0 = 16'hA701; bus.wt_data1 = 16'h0B01;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    wait_wrts(4, 200);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (40) @(negedge clk);
    if (wrt_own.size() == 4) begin
      chk("t2_own0", 32'(wrt_own[0]), 32'd0);
      chk("t2_own1", 32'(wrt_own[1]), 32'd1);
      chk("t2_own2", 32'(wrt_own[2]), 32'd0);
      chk("t2_own3", 32'(wrt_own[3]), 32'd1);
      chk("t2_gap", 32'(wrt_cyc[1] - wrt_cyc[0]), 32'd24);
      chk("t2_wt1", 32'(wrt_wt[1]), 32'h0B01);
    end
    chk("t2_nwrt", 32'(wrt_cyc.size()), 32'd4);
    chk("t2_ndone", 32'({n_done1[7:0], n_done0[7:0]}), 32'h0202);

    // Client 1 drops its request mid-transaction.
    clear_logs();
    bus.req1 = 1'b1;
    wait_gnt(1, 20);
    repeat (3) @(negedge clk);
    bus.req1 = 1'b0;
    wait_done(1, 60);
    repeat (40) @(negedge clk);
    chk("t3_nwrt", 32'(wrt_cyc.size()), 32'd1);
    chk("t3_ndone1", 32'(n_done1), 32'd1);
    chk("t3_rd", 32'(bus.rd_data), 32'h5A5A);

    // Client 0 back-to-back, then client 1 joins and is served next.
    clear_logs();
    rsp0 = 16'h1234; bus.req0 = 1'b1;
    wait_wrts(3, 200);
    bus.req1 = 1'b1;
    wait_done(1, 200);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (40) @(negedge clk);
    chk("t4_nwrt", 32'(wrt_cyc.size()), 32'd4);
    if (wrt_cyc.size() == 4) begin
      chk("t4_gap1", 32'(wrt_cyc[1] - wrt_cyc[0]), 32'd24);
      chk("t4_gap2", 32'(wrt_cyc[2] - wrt_cyc[1]), 32'd24);
      chk("t4_own3", 32'(wrt_own[3]), 32'd1);
    end
    chk("t4_rd", 32'(bus.rd_data), 32'h5A5A);

    // Stray spi_done while idle is ignored.
    clear_logs();
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    repeat (5) @(negedge clk);
    chk("t5_rd", 32'(bus.rd_data), 32'h5A5A);
    chk("t5_ndone", 32'(n_done0 + n_done1), 32'd0);
    chk("t5_busy", 32'(bus.busy), 32'd0);

    // Reset in the middle of a transaction, then a fresh request.
    clear_logs();
    rsp0 = 16'h0C3A; bus.wt_data0 = 16'hA702; bus.req0 = 1'b1;
    wait_gnt(0, 20);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    bus.req0 = 1'b0;
    @(posedge clk); #3;
    chk("t6_gnt", 32'({bus.gnt1, bus.gnt0}), 32'd0);
    chk("t6_busy", 32'(bus.busy), 32'd0);
    chk("t6_wrt", 32'(spi_wrt), 32'd0);
    chk("t6_ss", 32'({SS1_n, SS0_n}), 32'd3);
    chk("t6_rd", 32'(bus.rd_data), 32'd0);
    chk("t6_wt", 32'(spi_wt_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_nodone", 32'(n_done0), 32'd0);
    rsp0 = 16'h0F0F; bus.wt_data0 = 16'hA703; bus.req0 = 1'b1;
    wait_done(0, 60);
    chk("t6_rd2", 32'(bus.rd_data), 32'h0F0F);
    bus.req0 = 1'b0;
    repeat (20) @(negedge clk);
    chk("t6_ndone0", 32'(n_done0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
